button_conditioner: RTL and testbench

Per-button debouncer and pulse generator for the board's push-button inputs. It takes N already-synchronized button levels and turns each into a clean debounced level, a one-cycle press pulse, a one-cycle release pulse, and a one-cycle "step" pulse. The step pulse fires on press and then auto-repeats while the button is held. It sits between the input synchronizer stage and the game-control FSM, which moves the cursor on step pulses.

---
 rtl/button_conditioner.sv | 147 ++++++++++++++
 tb/tb_button_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
//
// Per-button debouncer and pulse generator. Each of the N channels takes an
// already-synchronized button level and produces a debounced level, a
// one-cycle press pulse, a one-cycle release pulse and a one-cycle step pulse.
// The step pulse fires on the accepted press and then auto-repeats while the
// button stays held.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   reset         asynchronous, active-low; clears all state and outputs
//   btn_in        [N] synchronized button levels, 1 = pressed
//   held          [N] debounced level, 1 = pressed
//   press_pulse   [N] one cycle when a press is accepted
//   release_pulse [N] one cycle when a release is accepted
//   step_pulse    [N] one cycle on accepted press and on each auto-repeat
//   dbg_state     [3*N] per-channel FSM state, channel i in bits [3*i +: 3]
//                 (IDLE=0, DEB_P=1, HOLD=2, RPT=3, DEB_R=4)
//
// Channels are fully independent: each one has its own FSM and counter.
module button_conditioner #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   btn_in,
  output logic [N-1:0]   held,
  output logic [N-1:0]   press_pulse,
  output logic [N-1:0]   release_pulse,
  output logic [N-1:0]   step_pulse,
  output logic [3*N-1:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEB_P = 3'd1,
    HOLD  = 3'd2,
    RPT   = 3'd3,
    DEB_R = 3'd4
  } state_t;

  // One counter per channel, sized for the largest terminal value.
  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t        st  [N];
  logic [CW-1:0] cnt [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      held          <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      step_pulse    <= '0;
    end else begin
      // Pulses are single-cycle: cleared every cycle unless a transition sets them.
      press_pulse   <= '0;
      release_pulse <= '0;
      step_pulse    <= '0;
      for (int i = 0; i < N; i++) begin
        case (st[i])
          IDLE: begin
            if (btn_in[i]) begin
              st[i]  <= DEB_P;
              cnt[i] <= CNT_ONE;
            end
          end
          DEB_P: begin
            if (!btn_in[i]) begin
              // Glitch shorter than the debounce window: drop it silently.
              st[i]  <= IDLE;
              cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              st[i]          <= HOLD;
              cnt[i]         <= '0;
              held[i]        <= 1'b1;
              press_pulse[i] <= 1'b1;
              step_pulse[i]  <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          HOLD: begin
            // A falling input takes priority over the repeat terminal count.
            if (!btn_in[i]) begin
              st[i]  <= DEB_R;
              cnt[i] <= CNT_ONE;
            end else if (cnt[i] == DELAY_LAST) begin
              st[i]         <= RPT;
              cnt[i]        <= '0;
              step_pulse[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          RPT: begin
            if (!btn_in[i]) begin
              st[i]  <= DEB_R;
              cnt[i] <= CNT_ONE;
            end else if (cnt[i] == RATE_LAST) begin
              cnt[i]        <= '0;
              step_pulse[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          DEB_R: begin
            if (btn_in[i]) begin
              // Release bounce: back to held, and the repeat delay starts over.
              st[i]  <= HOLD;
              cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              st[i]            <= IDLE;
              cnt[i]           <= '0;
              held[i]          <= 1'b0;
              release_pulse[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dbg
    assign dbg_state[3*g +: 3] = st[g];
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with N=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_RATE=3. Edge numbering restarts at 1 on the first
// rising edge after each reset release. Outputs are sampled 1 time unit after
// the rising edge; inputs change at the same point, i.e. before the next edge.
module tb_button_conditioner;

  localparam int N = 2;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] held;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] step_pulse;
  logic [3*N-1:0] dbg_state;

  int total;
  int bad;

  button_conditioner #(
    .N(N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_RATE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .held(held),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .step_pulse(step_pulse),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for a cycle with btn_in already at b, then releases it
  // 1 unit after a rising edge so the next edge is edge 1.
  task automatic apply_reset(input logic [N-1:0] b);
    tick();
    reset  = 1'b0;
    btn_in = b;
    tick();
    reset  = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4*N-1:0] obs;
    reset  = 1'b0;
    btn_in = '0;
    #3;
    obs = {held, press_pulse, release_pulse, step_pulse};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got=%b want=%b", obs, 8'b0);
    end
    total++;
    if (dbg_state !== '0) begin
      bad++;
      $display("FAIL reset_state: got=%b want=%b", dbg_state, 6'b0);
    end
  endtask

  task automatic test_clean_press_release();
    logic [4*N-1:0] obs, exp;
    apply_reset(2'b01);
    for (int e = 1; e <= 40; e++) begin
      if (e == 30) btn_in[0] = 1'b0;
      tick();
      exp = '0;
      exp[6] = (e >= 4 && e < 33);                                    // held[0]
      exp[4] = (e == 4);                                              // press_pulse[0]
      exp[2] = (e == 33);                                             // release_pulse[0]
      exp[0] = (e == 4) || (e >= 12 && e <= 27 && (e - 12) % 3 == 0); // step_pulse[0]
      obs = {held, press_pulse, release_pulse, step_pulse};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL clean_press edge=%0d: got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [4*N-1:0] obs;
    apply_reset(2'b01);
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) btn_in[0] = 1'b0;
      tick();
      obs = {held, press_pulse, release_pulse, step_pulse};
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL glitch edge=%0d: got=%b want=%b", e, obs, 8'b0);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [4*N-1:0] obs, exp;
    int rel_count;
    rel_count = 0;
    apply_reset(2'b01);
    for (int e = 1; e <= 16; e++) begin
      if (e == 6) btn_in[0] = 1'b0;
      if (e == 8) btn_in[0] = 1'b1;
      if (e == 9) btn_in[0] = 1'b0;
      tick();
      exp = '0;
      exp[6] = (e >= 4 && e < 12);
      exp[4] = (e == 4);
      exp[2] = (e == 12);
      exp[0] = (e == 4);
      obs = {held, press_pulse, release_pulse, step_pulse};
      if (release_pulse[0] === 1'b1) rel_count++;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL release_bounce edge=%0d: got=%b want=%b", e, obs, exp);
      end
    end
    total++;
    if (rel_count !== 1) begin
      bad++;
      $display("FAIL release_bounce_count: got=%0d want=1", rel_count);
    end
  endtask

  task automatic test_independent();
    logic [4*N-1:0] obs, exp;
    apply_reset(2'b00);
    for (int e = 1; e <= 24; e++) begin
      if (e == 1)  btn_in[0] = 1'b1;
      if (e == 3)  btn_in[1] = 1'b1;
      if (e == 14) btn_in[0] = 1'b0;
      if (e == 16) btn_in[1] = 1'b0;
      tick();
      exp = '0;
      exp[6] = (e >= 4 && e < 17);
      exp[7] = (e >= 6 && e < 19);
      exp[4] = (e == 4);
      exp[5] = (e == 6);
      exp[2] = (e == 17);
      exp[3] = (e == 19);
      exp[0] = (e == 4 || e == 12);
      exp[1] = (e == 6 || e == 14);
      obs = {held, press_pulse, release_pulse, step_pulse};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL independent edge=%0d: got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4*N-1:0] obs, exp;
    apply_reset(2'b01);
    for (int e = 1; e <= 12; e++) tick();
    // Edge 12 is the first repeat step; channel 0 is now in RPT.
    total++;
    if (step_pulse[0] !== 1'b1 || dbg_state[2:0] !== 3'd3) begin
      bad++;
      $display("FAIL async_pre_rpt: got step=%b state=%0d want step=1 state=3",
               step_pulse[0], dbg_state[2:0]);
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {held, press_pulse, release_pulse, step_pulse};
    total++;
    if (obs !== '0 || dbg_state !== '0) begin
      bad++;
      $display("FAIL async_clear: got=%b state=%b want=%b state=%b",
               obs, dbg_state, 8'b0, 6'b0);
    end
    #1;
    reset = 1'b1;
    // btn_in[0] is still 1: a fresh press is accepted on edge 4.
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = '0;
      exp[6] = (e >= 4);
      exp[4] = (e == 4);
      exp[0] = (e == 4);
      obs = {held, press_pulse, release_pulse, step_pulse};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL async_repress edge=%0d: got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    btn_in = '0;
    test_reset();
    test_clean_press_release();
    test_glitch();
    test_release_bounce();
    test_independent();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
